// File: rtl/uart_rx_if.sv
// Host-side handshake bundle for the UART receiver.
// The receiver uses the "slave" modport. The consumer uses the "master" modport.
//   read_ack      consumer -> rx   take the held byte
//   read_data     rx -> consumer   last received byte
//   data_ready    rx -> consumer   read_data valid and not yet taken
//   parity_error  rx -> consumer   held byte failed odd parity
//   framing_error rx -> consumer   held byte had a low stop bit
//   overrun       rx -> consumer   held byte replaced an unread one
//   busy          rx -> consumer   receiver is inside a frame (or a break)
interface uart_rx_if;
    logic       read_ack;
    logic [7:0] read_data;
    logic       data_ready;
    logic       parity_error;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    modport slave (
        input  read_ack,
        output read_data,
        output data_ready,
        output parity_error,
        output framing_error,
        output overrun,
        output busy
    );

    modport master (
        output read_ack,
        input  read_data,
        input  data_ready,
        input  parity_error,
        input  framing_error,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, 8 data bits (LSB first), 1 odd-parity bit and
// 1 stop bit. The rx line is sampled at mid-bit using a clock-divider counter.
// One received byte and its error flags are held for a host-side consumer.
// Ports:
//   clock  in   system clock, all logic on posedge
//   reset  in   synchronous, active-high
//   rx     in   asynchronous serial line, idle high
//   host   if   consumer handshake (see uart_rx_if, slave modport)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for a falling edge on rx_s
// S_START  | in start bit, confirm it is still low at mid-bit
// S_DATA   | sampling 8 data bits at mid-bit, LSB first
// S_PARITY | sampling the parity bit
// S_STOP   | sampling the stop bit, byte delivered at that sample
// S_BREAK  | stop bit was low, wait for the line to return high
module uart_rx #(
    parameter int CLOCK_FREQ = 12_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic clock,
    input  logic reset,
    input  logic rx,
    uart_rx_if.slave host
);

    localparam int CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT       = CLOCKS_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta, rx_s;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       bit_pos_q, bit_pos_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             half_end, bit_end;
    logic             deliver;
    logic             take;

    logic [7:0]       data_q;
    logic             ready_q;
    logic             perr_q;
    logic             ferr_q;
    logic             ovr_q;

    assign half_end = (count_q == CNT_W'(HALF_BIT - 1));
    assign bit_end  = (count_q == CNT_W'(CLOCKS_PER_BIT - 1));

    // Two-flop synchronizer; idles high so reset never looks like a start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            bit_pos_q <= 3'd0;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bit_pos_q <= bit_pos_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_pos_d = bit_pos_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        deliver   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (half_end) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_pos_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d[bit_pos_q] = rx_s;
                    if (bit_pos_q == 3'd7) state_d = S_PARITY;
                    else                   bit_pos_d = bit_pos_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    parity_d = rx_s;
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    deliver = 1'b1;
                    state_d = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The counter restarts on each state change and at the end of every
        // data bit, so the same compare value marks mid-bit throughout.
        count_d = count_q + CNT_W'(1);
        if (state_d != state_q || bit_end ||
            state_q == S_IDLE || state_q == S_BREAK) begin
            count_d = '0;
        end
    end

    // An ack only counts when a byte is actually held.
    assign take = host.read_ack && ready_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (deliver) begin
            // An ack in the delivery cycle consumes the old byte, so no overrun.
            data_q  <= shift_q;
            ready_q <= 1'b1;
            perr_q  <= (parity_q != ~(^shift_q));
            ferr_q  <= ~rx_s;
            ovr_q   <= ready_q && !host.read_ack;
        end else if (take) begin
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign host.read_data     = data_q;
    assign host.data_ready    = ready_q;
    assign host.parity_error  = perr_q;
    assign host.framing_error = ferr_q;
    assign host.overrun       = ovr_q;
    assign host.busy          = (state_q != S_IDLE);

endmodule
